// File: rtl/display_scheduler.sv
// Rotating four-source binary-to-BCD display scheduler using a serial double-dabble converter.
// Optional build macro DISPLAY_SCHED_BLANK_EN shows leading zero digits as 4'hF.
module display_scheduler #(
  parameter int unsigned DWELL_CYCLES = 50000
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [3:0]   req_i,
  input  logic [127:0] data_i,
  input  logic [3:0]   clr_i,
  output logic [3:0]   ack_o,
  output logic [31:0]  digits_o,
  output logic [1:0]   src_id_o,
  output logic         ovf_o,
  output logic         upd_o,
  output logic         busy_o
);

  localparam int unsigned CNT_W  = $clog2(DWELL_CYCLES);
  localparam int unsigned BIN_W  = 32;
  localparam int unsigned BCD_W  = 40;
  localparam int unsigned STEP_W = 5;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_dwell;
  logic                w_tick;
  logic [BIN_W-1:0]    r_value [4];
  logic [3:0]          r_valid;
  logic [1:0]          r_last;
  logic [1:0]          r_sel;
  logic [1:0]          w_sel;
  logic                w_found;
  logic                w_load;
  logic [STEP_W-1:0]   r_step;
  logic [BIN_W-1:0]    r_bin;
  logic [BCD_W-1:0]    r_bcd;
  logic [BCD_W-1:0]    w_adj;
  logic [31:0]         w_digits;
  logic                w_zero;

  assign w_tick = (r_dwell == CNT_W'(DWELL_CYCLES - 1));

  // Free-running dwell counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_dwell <= '0;
    else if (w_tick) r_dwell <= '0;
    else r_dwell <= r_dwell + CNT_W'(1);
  end

  // Source registers; a write beats a simultaneous clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 4; k++) r_value[k] <= '0;
      r_valid <= '0;
      ack_o   <= '0;
    end else begin
      for (int k = 0; k < 4; k++)
        if (req_i[k]) r_value[k] <= data_i[32*k +: 32];
      r_valid <= req_i | (r_valid & ~clr_i);
      ack_o   <= req_i;
    end
  end

  // Round-robin pick starting after the last displayed source
  always_comb begin
    w_sel   = r_last;
    w_found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if (!w_found && r_valid[r_last + 2'(i)]) begin
        w_sel   = r_last + 2'(i);
        w_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_tick && w_found) begin
          w_state_nxt = SHIFT;
          w_load      = 1'b1;
        end
      end
      SHIFT:   if (r_step == STEP_W'(BIN_W - 1)) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_adj = r_bcd;
    for (int j = 0; j < 10; j++)
      if (r_bcd[4*j +: 4] >= 4'd5) w_adj[4*j +: 4] = r_bcd[4*j +: 4] + 4'd3;
  end

`ifdef DISPLAY_SCHED_BLANK_EN
  // Blank a digit when it and every digit above it are zero; digit 0 always shows
  always_comb begin
    w_digits = r_bcd[31:0];
    w_zero   = (r_bcd[39:32] == 8'd0);
    for (int j = 7; j >= 1; j--) begin
      w_zero = w_zero && (r_bcd[4*j +: 4] == 4'd0);
      if (w_zero) w_digits[4*j +: 4] = 4'hF;
    end
  end
`else
  always_comb begin
    w_digits = r_bcd[31:0];
    w_zero   = 1'b0;
  end
`endif

  // Converter datapath and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_step   <= '0;
      r_bin    <= '0;
      r_bcd    <= '0;
      r_sel    <= '0;
      r_last   <= 2'd3;
      digits_o <= '0;
      src_id_o <= '0;
      ovf_o    <= 1'b0;
      upd_o    <= 1'b0;
      busy_o   <= 1'b0;
    end else begin
      upd_o <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_load) begin
            r_sel  <= w_sel;
            r_bin  <= r_value[w_sel];
            r_bcd  <= '0;
            r_step <= '0;
            busy_o <= 1'b1;
          end
        end
        SHIFT: begin
          r_bcd  <= {w_adj[BCD_W-2:0], r_bin[BIN_W-1]};
          r_bin  <= {r_bin[BIN_W-2:0], 1'b0};
          r_step <= r_step + STEP_W'(1);
        end
        DONE: begin
          digits_o <= w_digits;
          src_id_o <= r_sel;
          ovf_o    <= |r_bcd[39:32];
          r_last   <= r_sel;
          upd_o    <= 1'b1;
          busy_o   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
